// File: rtl/ncl_tb_pkg.sv
// ncl_tb_pkg: shared FSM encoding and field widths for the response checker
package ncl_tb_pkg;
    localparam int CNT_W = 16;
    localparam int WGT_W = 4;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
endpackage

// File: rtl/ncl_th_model.sv
// ncl_th_model: weighted THmn reference with hysteresis, updated only when en is high
module ncl_th_model
    import ncl_tb_pkg::*;
#(
    parameter int N = 3,
    parameter int THRESHOLD = 3,
    parameter logic [N*WGT_W-1:0] WEIGHTS = {N{4'h1}}
) (
    input  logic         clk,
    input  logic         rsb,
    input  logic [N-1:0] x,
    input  logic         en,
    output logic         exp_out
);
    localparam int SW = $clog2(15 * N + 1);
    logic [SW-1:0] sum;
    logic          y;
    // weighted sum of asserted inputs, wide enough for all weights at 15
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            if (x[i]) sum = sum + SW'(WEIGHTS[i*WGT_W +: WGT_W]);
    end
    assign exp_out = (int'(sum) >= THRESHOLD) ? 1'b1 : (x == '0) ? 1'b0 : y;
    // hysteresis state: keeps the last expected value between set and clear
    always_ff @(posedge clk or negedge rsb)
        if (!rsb) y <= 1'b0;
        else if (en) y <= exp_out;
endmodule

// File: rtl/response_checker.sv
// response_checker: samples a gate under test after each stimulus change and counts mismatches
// Optional first-failure capture is enabled by defining RESP_CHECK_FAIL_CAPTURE_EN.
module response_checker
    import ncl_tb_pkg::*;
#(
    parameter int INPUT_PORTS = 3,
    parameter int THRESHOLD = 3,
    parameter logic [INPUT_PORTS*WGT_W-1:0] WEIGHTS = {INPUT_PORTS{4'h1}},
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rsb,
    input  logic [INPUT_PORTS-1:0] stm_value,
    input  logic                   gnt,
    input  logic                   dut_out,
    output logic [CNT_W-1:0]       vec_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   mismatch,
    output logic                   done,
    output logic                   pass,
    output logic [INPUT_PORTS-1:0] first_fail_vec
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
    state_t                 state, state_n;
    logic [3:0]             cnt, cnt_n;
    logic [INPUT_PORTS-1:0] stm_q;
    logic                   chg, check, exp_out;
    assign chg      = stm_value != stm_q;
    assign check    = state == CHECK;
    assign mismatch = check && (exp_out != dut_out);
    assign done     = state == DONE;
    assign pass     = done && (err_cnt == '0);
    ncl_th_model #(.N(INPUT_PORTS), .THRESHOLD(THRESHOLD), .WEIGHTS(WEIGHTS)) u_model (
        .clk(clk), .rsb(rsb), .x(stm_q), .en(check), .exp_out(exp_out)
    );
    // state, settle counter, registered stimulus and saturating counters
    always_ff @(posedge clk or negedge rsb)
        if (!rsb) begin
            state   <= IDLE;
            cnt     <= '0;
            stm_q   <= '0;
            vec_cnt <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            stm_q <= stm_value;
            if (check && vec_cnt != '1) vec_cnt <= vec_cnt + 1'b1;
            if (mismatch && err_cnt != '0 - 1'b1) err_cnt <= err_cnt + 1'b1;
        end
    // next state: a change restarts settling; gnt only finishes after a pending check
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE:   if (gnt) state_n = DONE;
                    else if (chg) begin state_n = SETTLE; cnt_n = CNT_LOAD; end
            SETTLE: if (chg) cnt_n = CNT_LOAD;
                    else if (cnt <= 4'd1) begin state_n = CHECK; cnt_n = '0; end
                    else cnt_n = cnt - 1'b1;
            CHECK:  if (gnt) state_n = DONE;
                    else if (chg) begin state_n = SETTLE; cnt_n = CNT_LOAD; end
                    else state_n = IDLE;
            DONE:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
`ifdef RESP_CHECK_FAIL_CAPTURE_EN
    logic [INPUT_PORTS-1:0] ffv_q;
    // latch the stimulus of the first mismatch since reset
    always_ff @(posedge clk or negedge rsb)
        if (!rsb) ffv_q <= '0;
        else if (mismatch && err_cnt == '0) ffv_q <= stm_q;
    assign first_fail_vec = ffv_q;
`else
    assign first_fail_vec = '0;
`endif
endmodule

// File: tb/tb_response_checker.sv
// tb_response_checker: scoreboard bench for response_checker (TH23, settle 2)
module tb_response_checker;
    logic        clk = 1'b0, rsb = 1'b0, gnt = 1'b0, dut_out = 1'b0;
    logic [2:0]  stm_value = '0;
    logic [15:0] vec_cnt, err_cnt;
    logic        mismatch, done, pass;
    logic [2:0]  first_fail_vec;
    logic [2:0]  ffv_exp;
    int errors = 0, checks = 0;
    typedef struct {logic mis; logic [15:0] err;} exp_t;
    exp_t q[$];
    exp_t e;
    logic [15:0] last_vec = '0;
    logic        seen = 1'b0;

    always #5 clk = ~clk;

    response_checker #(.INPUT_PORTS(3), .THRESHOLD(2), .WEIGHTS(12'h111), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rsb(rsb), .stm_value(stm_value), .gnt(gnt), .dut_out(dut_out),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .mismatch(mismatch), .done(done),
        .pass(pass), .first_fail_vec(first_fail_vec)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: each completed check pops one expected response
    always @(negedge clk) begin
        if (!rsb) begin
            last_vec = '0;
            seen = 1'b0;
        end else begin
            if (vec_cnt != last_vec) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_check: vec_cnt=%0d with no expected entry", vec_cnt);
                end else begin
                    e = q.pop_front();
                    chk("sb_mismatch", 32'(seen), 32'(e.mis));
                    chk("sb_err_cnt", 32'(err_cnt), 32'(e.err));
                end
                seen = 1'b0;
            end
            if (mismatch) seen = 1'b1;
            last_vec = vec_cnt;
        end
    end

    task automatic step(input logic [2:0] v, input logic d, input logic mis, input logic [15:0] er);
        @(posedge clk);
        #1;
        stm_value = v;
        dut_out = d;
        q.push_back('{mis, er});
        repeat (4) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rsb = 1'b0;
        gnt = 1'b0;
        stm_value = '0;
        dut_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rsb = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef RESP_CHECK_FAIL_CAPTURE_EN
        ffv_exp = 3'b011;
`else
        ffv_exp = 3'b000;
`endif
        @(negedge clk);
        chk("rst_vec_cnt", vec_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_ffv", first_fail_vec, 0);
        @(posedge clk);
        #1 rsb = 1'b1;
        // clean sweep against a correct TH23
        step(3'b011, 1'b1, 1'b0, 16'd0);
        step(3'b001, 1'b1, 1'b0, 16'd0);
        step(3'b000, 1'b0, 1'b0, 16'd0);
        step(3'b101, 1'b1, 1'b0, 16'd0);
        step(3'b000, 1'b0, 1'b0, 16'd0);
        drain();
        #1 gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("sweep_vec_cnt", vec_cnt, 5);
        chk("sweep_err_cnt", err_cnt, 0);
        chk("sweep_done", done, 1);
        chk("sweep_pass", pass, 1);
        @(posedge clk);
        #1 stm_value = 3'b111;
        repeat (6) @(negedge clk);
        chk("done_ignores_vec", vec_cnt, 5);
        chk("done_terminal", done, 1);
        // stuck-at-0 output: pulse two cycles after the change
        do_reset();
        @(posedge clk);
        #1;
        stm_value = 3'b011;
        dut_out = 1'b0;
        q.push_back('{1'b1, 16'd1});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("mis_timing_c%0d", c), mismatch, c == 2);
        end
        drain();
        #1 gnt = 1'b1;
        repeat (2) @(negedge clk);
        chk("stuck_err_cnt", err_cnt, 1);
        chk("stuck_done", done, 1);
        chk("stuck_pass", pass, 0);
        chk("stuck_ffv", first_fail_vec, ffv_exp);
        // hysteresis hold
        do_reset();
        step(3'b011, 1'b1, 1'b0, 16'd0);
        step(3'b001, 1'b1, 1'b0, 16'd0);
        step(3'b000, 1'b0, 1'b0, 16'd0);
        step(3'b011, 1'b1, 1'b0, 16'd0);
        step(3'b001, 1'b0, 1'b1, 16'd1);
        drain();
        chk("hyst_vec_cnt", vec_cnt, 5);
        chk("hyst_err_cnt", err_cnt, 1);
        // back-to-back changes collapse into one check on the last vector
        do_reset();
        @(posedge clk);
        #1 stm_value = 3'b001;
        dut_out = 1'b1;
        @(posedge clk);
        #1 stm_value = 3'b011;
        @(posedge clk);
        #1 stm_value = 3'b111;
        q.push_back('{1'b0, 16'd0});
        repeat (6) @(negedge clk);
        drain();
        chk("burst_vec_cnt", vec_cnt, 1);
        // reset mid-settle abandons the check; nonzero stimulus on release counts
        do_reset();
        @(posedge clk);
        #1 stm_value = 3'b011;
        dut_out = 1'b0;
        @(posedge clk);
        #1 rsb = 1'b0;
        @(posedge clk);
        #1 dut_out = 1'b1;
        q.push_back('{1'b0, 16'd0});
        rsb = 1'b1;
        @(negedge clk);
        chk("midrst_vec_cnt", vec_cnt, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_ffv", first_fail_vec, 0);
        repeat (5) @(negedge clk);
        drain();
        chk("release_vec_cnt", vec_cnt, 1);
        // error counter saturation
        do_reset();
        @(negedge clk);
        force dut.err_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt;
        step(3'b011, 1'b0, 1'b1, 16'hFFFF);
        drain();
        chk("sat_err_cnt", err_cnt, 16'hFFFF);
        chk("sat_vec_cnt", vec_cnt, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
